// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle RV32I control FSM and ALU decoder; optional memory
//            wait-state support when MULTICYCLE_MEMWAIT_EN is defined.
// Revision : 1.0
// ============================================================================
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_instr,
    output logic [3:0] state
);

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_mem_go;
    logic       w_illegal;
    logic       w_pcupdate;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_adrsrc;
    logic [1:0] w_resultsrc;
    logic [1:0] w_srca;
    logic [1:0] w_srcb;
    logic [1:0] w_aluop;

`ifdef MULTICYCLE_MEMWAIT_EN
    assign w_mem_go = mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_go           = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:    w_next = w_mem_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    c_op_load, c_op_store: w_next = S_MEMADR;
                    c_op_rtype:            w_next = S_EXECR;
                    c_op_itype:            w_next = S_EXECI;
                    c_op_branch:           w_next = S_BEQ;
                    c_op_jal:              w_next = S_JAL;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   w_next = (op == c_op_store) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = w_mem_go ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: w_next = w_mem_go ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI:    w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Moore decode of the registered state.
    always_comb begin
        w_pcupdate  = 1'b0;
        w_branch    = 1'b0;
        w_irwrite   = 1'b0;
        w_memwrite  = 1'b0;
        w_regwrite  = 1'b0;
        w_adrsrc    = 1'b0;
        w_resultsrc = 2'b00;
        w_srca      = 2'b00;
        w_srcb      = 2'b00;
        w_aluop     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_srcb      = 2'b10;
                w_resultsrc = 2'b10;
                w_pcupdate  = 1'b1;
            end
            S_DECODE: begin
                w_srca = 2'b01;
                w_srcb = 2'b01;
            end
            S_MEMADR: begin
                w_srca = 2'b10;
                w_srcb = 2'b01;
            end
            S_MEMREAD: w_adrsrc = 1'b1;
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECR: begin
                w_srca  = 2'b10;
                w_aluop = 2'b10;
            end
            S_EXECI: begin
                w_srca  = 2'b10;
                w_srcb  = 2'b01;
                w_aluop = 2'b10;
            end
            S_ALUWB: w_regwrite = 1'b1;
            S_BEQ: begin
                w_srca   = 2'b10;
                w_aluop  = 2'b01;
                w_branch = 1'b1;
            end
            S_JAL: begin
                w_srca     = 2'b01;
                w_srcb     = 2'b10;
                w_pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (w_aluop)
            2'b01:   ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b001:  ALUControl = 3'b100;
                    3'b010:  ALUControl = 3'b101;
                    3'b100:  ALUControl = 3'b111;
                    3'b101:  ALUControl = 3'b110;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            c_op_store:  ImmSrc = 2'b01;
            c_op_branch: ImmSrc = 2'b10;
            c_op_jal:    ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end

    // Write enables are gated by reset directly so an abort takes effect at once.
    assign PCWrite       = (w_pcupdate | (w_branch & zero)) & reset;
    assign IRWrite       = w_irwrite & reset;
    assign MemWrite      = w_memwrite & reset;
    assign RegWrite      = w_regwrite & reset;
    assign AdrSrc        = w_adrsrc;
    assign ResultSrc     = w_resultsrc;
    assign ALUSrcA       = w_srca;
    assign ALUSrcB       = w_srcb;
    assign illegal_instr = w_illegal;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed self-checking bench for multicycle_ctrl.
// Revision : 1.0
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal_instr;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegWrite     (RegWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ImmSrc       (ImmSrc),
        .ALUControl   (ALUControl),
        .illegal_instr(illegal_instr),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input logic [6:0] i_op, input logic [2:0] i_f3, input logic i_f7,
                           input logic [3:0] exp_state, input logic [2:0] exp_alu);
        op       = i_op;
        funct3   = i_f3;
        funct7b5 = i_f7;
        tick();
        check("alu_decode_state", state, 4'd1);
        tick();
        check("alu_exec_state", state, exp_state);
        check("alu_control", ALUControl, exp_alu);
        check("alu_exec_regwrite", RegWrite, 1'b0);
        tick();
        check("alu_wb_state", state, 4'd8);
        check("alu_wb_regwrite", RegWrite, 1'b1);
        tick();
        check("alu_back_fetch", state, 4'd0);
    endtask

    initial begin
        reset     = 1'b1;
        op        = 7'd0;
        funct3    = 3'd0;
        funct7b5  = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_state", state, 4'd0);
        check("rst_irwrite", IRWrite, 1'b0);
        check("rst_pcwrite", PCWrite, 1'b0);
        check("rst_alusrcb", ALUSrcB, 2'b10);
        check("rst_resultsrc", ResultSrc, 2'b10);
        tick();
        tick();
        check("rst_hold_state", state, 4'd0);
        reset = 1'b1;
        #1;
        check("rel_irwrite", IRWrite, 1'b1);
        check("rel_pcwrite", PCWrite, 1'b1);

        // lw: 0,1,2,3,4,0
        op = 7'b0000011;
        tick();
        check("lw_s1", state, 4'd1);
        check("lw_dec_srca", ALUSrcA, 2'b01);
        check("lw_dec_srcb", ALUSrcB, 2'b01);
        tick();
        check("lw_s2", state, 4'd2);
        check("lw_adr_srca", ALUSrcA, 2'b10);
        check("lw_adr_alu", ALUControl, 3'b000);
        tick();
        check("lw_s3", state, 4'd3);
        check("lw_rd_adrsrc", AdrSrc, 1'b1);
        check("lw_rd_regwrite", RegWrite, 1'b0);
        tick();
        check("lw_s4", state, 4'd4);
        check("lw_wb_regwrite", RegWrite, 1'b1);
        check("lw_wb_resultsrc", ResultSrc, 2'b01);
        tick();
        check("lw_s0", state, 4'd0);
        check("lw_fetch_regwrite", RegWrite, 1'b0);

        // sw: 0,1,2,5,0
        op = 7'b0100011;
        tick();
        check("sw_immsrc", ImmSrc, 2'b01);
        tick();
        check("sw_s2", state, 4'd2);
        tick();
        check("sw_s5", state, 4'd5);
        check("sw_memwrite", MemWrite, 1'b1);
        check("sw_adrsrc", AdrSrc, 1'b1);
`ifdef MULTICYCLE_MEMWAIT_EN
        mem_ready = 1'b0;
        tick();
        check("sw_wait1_state", state, 4'd5);
        check("sw_wait1_memwrite", MemWrite, 1'b1);
        tick();
        check("sw_wait2_state", state, 4'd5);
        check("sw_wait2_memwrite", MemWrite, 1'b1);
        mem_ready = 1'b1;
`endif
        tick();
        check("sw_s0", state, 4'd0);
        check("sw_fetch_memwrite", MemWrite, 1'b0);

        run_alu(7'b0110011, 3'b000, 1'b1, 4'd6, 3'b001);
        run_alu(7'b0110011, 3'b000, 1'b0, 4'd6, 3'b000);
        run_alu(7'b0110011, 3'b101, 1'b0, 4'd6, 3'b110);
        run_alu(7'b0010011, 3'b000, 1'b1, 4'd7, 3'b000);
        run_alu(7'b0010011, 3'b111, 1'b0, 4'd7, 3'b010);

        // beq
        op   = 7'b1100011;
        zero = 1'b1;
        tick();
        tick();
        check("beq_state", state, 4'd9);
        check("beq_pcwrite_taken", PCWrite, 1'b1);
        check("beq_alu", ALUControl, 3'b001);
        check("beq_immsrc", ImmSrc, 2'b10);
        zero = 1'b0;
        #1;
        check("beq_pcwrite_not_taken", PCWrite, 1'b0);
        tick();
        check("beq_back_fetch", state, 4'd0);

        // jal
        op = 7'b1101111;
        tick();
        tick();
        check("jal_state", state, 4'd10);
        check("jal_pcwrite", PCWrite, 1'b1);
        check("jal_srca", ALUSrcA, 2'b01);
        check("jal_immsrc", ImmSrc, 2'b11);
        tick();
        check("jal_back_fetch", state, 4'd0);

        // illegal
        op = 7'b1110011;
        #1;
        check("ill_fetch_flag", illegal_instr, 1'b0);
        tick();
        check("ill_dec_state", state, 4'd1);
        check("ill_flag", illegal_instr, 1'b1);
        check("ill_regwrite", RegWrite, 1'b0);
        check("ill_memwrite", MemWrite, 1'b0);
        tick();
        check("ill_back_fetch", state, 4'd0);
        check("ill_flag_clear", illegal_instr, 1'b0);

        // reset mid-EXECR
        op       = 7'b0110011;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        tick();
        tick();
        check("mid_exec_state", state, 4'd6);
        reset = 1'b0;
        #1;
        check("mid_rst_state", state, 4'd0);
        check("mid_rst_irwrite", IRWrite, 1'b0);
        check("mid_rst_pcwrite", PCWrite, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_hold_state", state, 4'd0);
            check("mid_rst_hold_regwrite", RegWrite, 1'b0);
        end
        reset = 1'b1;
        #1;
        check("mid_rel_irwrite", IRWrite, 1'b1);
        tick();
        check("mid_rel_decode", state, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
